// File: rtl/da_reorder_ctrl_if.sv
// Sample-stream and register-file bus for the 8-point reorder controller.
// The slave modport is the controller's view; master is the environment (source, sink, file).
interface da_reorder_ctrl_if #(
  parameter int DATA_WIDTH = 17
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_real;
  logic [DATA_WIDTH-1:0] in_imag;

  logic                  out_valid;
  logic                  out_sop;
  logic [DATA_WIDTH-1:0] out_real;
  logic [DATA_WIDTH-1:0] out_imag;

  logic                  rf_wen;
  logic                  rf_ren;
  logic [2:0]            rf_waddr;
  logic [2:0]            rf_raddr;
  logic [DATA_WIDTH-1:0] rf_din_real;
  logic [DATA_WIDTH-1:0] rf_din_imag;
  logic [DATA_WIDTH-1:0] rf_dout_real;
  logic [DATA_WIDTH-1:0] rf_dout_imag;

  modport master (
    output in_valid, in_real, in_imag, rf_dout_real, rf_dout_imag,
    input  in_ready, out_valid, out_sop, out_real, out_imag,
    input  rf_wen, rf_ren, rf_waddr, rf_raddr, rf_din_real, rf_din_imag
  );

  modport slave (
    input  in_valid, in_real, in_imag, rf_dout_real, rf_dout_imag,
    output in_ready, out_valid, out_sop, out_real, out_imag,
    output rf_wen, rf_ren, rf_waddr, rf_raddr, rf_din_real, rf_din_imag
  );
endinterface

// File: rtl/da_reorder_ctrl.sv
// 8-sample frame reorder controller: fills an external register file, then drains
// it in 3-bit bit-reversed (or natural) order; frames never overlap.
module da_reorder_ctrl #(
  parameter int DATA_WIDTH = 17,
  parameter int BITREV     = 1
) (
  input  logic              clk,
  input  logic              rst,
  da_reorder_ctrl_if.slave  bus
);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] wcnt;
  logic [2:0] rcnt;
  logic       out_valid_q;
  logic       out_sop_q;

  logic       ready;
  logic       accept;
  logic       ren;
  logic [2:0] raddr;

  // Handshake and enables are gated by rst so they drop the moment reset rises,
  // not only after the state register has been cleared.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    accept    = 1'b0;
    ren       = 1'b0;
    case (state)
      FILL: begin
        ready  = ~rst;
        accept = ready & bus.in_valid;
        if (accept && (wcnt == 3'd7)) state_nxt = DRAIN;
      end
      DRAIN: begin
        ren = ~rst;
        if (rcnt == 3'd7) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    raddr = '0;
    if (ren) begin
      if (BITREV != 0) raddr = {rcnt[0], rcnt[1], rcnt[2]};
      else             raddr = rcnt;
    end
  end

  // rcnt is held at zero through FILL so every drain starts at address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      wcnt        <= '0;
      rcnt        <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) wcnt <= wcnt + 3'd1;
      if (state == FILL) rcnt <= '0;
      else               rcnt <= rcnt + 3'd1;
      out_valid_q <= ren;
      out_sop_q   <= ren & (rcnt == 3'd0);
    end
  end

  assign bus.in_ready     = ready;
  assign bus.rf_wen       = accept;
  assign bus.rf_waddr     = wcnt;
  assign bus.rf_din_real  = accept ? bus.in_real : {DATA_WIDTH{1'b0}};
  assign bus.rf_din_imag  = accept ? bus.in_imag : {DATA_WIDTH{1'b0}};
  assign bus.rf_ren       = ren;
  assign bus.rf_raddr     = raddr;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sop      = out_sop_q;
  assign bus.out_real     = bus.rf_dout_real;
  assign bus.out_imag     = bus.rf_dout_imag;

endmodule
